// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv32i_pkg
// Brief  : RV32I opcodes, legal-opcode check and sequencer state encodings.
// Rev    : 1.0
// ============================================================================
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_DBG    = 3'd6,
        S_HALT   = 3'd7
    } seq_state_t;

    // FENCE (MISC-MEM) is base RV32I and executes as a no-op here.
    function automatic logic is_legal_opcode(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE, OPC_SYSTEM, OPC_OP, OPC_OP_IMM, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_MISC_MEM:
                is_legal_opcode = 1'b1;
            default:
                is_legal_opcode = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_mc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : rv32i_mc_sequencer_if
// Brief  : Control/status bundle between the sequencer and the datapath.
// Rev    : 1.0
// ============================================================================
interface rv32i_mc_sequencer_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             run;
    logic [XLEN-1:0]  inst_rdata;
    logic             regwen_dec;
    logic             dbg_req;
    logic [XLEN-1:0]  ir;
    logic             pc_we;
    logic             rf_we;
    logic             imem_csb;
    logic             dmem_csb;
    logic             dmem_web;
    logic             dbg_gnt;
    logic             halted;
    logic             trap_illegal;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    modport master (
        input  run, inst_rdata, regwen_dec, dbg_req,
        output ir, pc_we, rf_we, imem_csb, dmem_csb, dmem_web, dbg_gnt,
               halted, trap_illegal, cycle_cnt, instret_cnt
    );

    modport slave (
        output run, inst_rdata, regwen_dec, dbg_req,
        input  ir, pc_we, rf_we, imem_csb, dmem_csb, dmem_web, dbg_gnt,
               halted, trap_illegal, cycle_cnt, instret_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rv32i_perf_counter.sv
`default_nettype none
// ============================================================================
// Module : rv32i_perf_counter
// Brief  : Free-running wrap-around event counter with sync reset and enable.
// Rev    : 1.0
// ============================================================================
module rv32i_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/rv32i_mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : rv32i_mc_sequencer
// Brief  : Multi-cycle RV32I phase sequencer with IR, debug grant and counters.
// Rev    : 1.0
// ============================================================================
module rv32i_mc_sequencer
    import rv32i_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    rv32i_mc_sequencer_if.master bus
);
    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [XLEN-1:0]  r_ir;
    logic [6:0]       w_opcode;
    logic             w_illegal;
    logic             w_halt_op;
    logic             w_mem_op;

    logic             w_imem_csb, w_dmem_csb, w_dmem_web;
    logic             w_pc_we, w_rf_we, w_dbg_gnt, w_halted;
    logic             r_imem_csb, r_dmem_csb, r_dmem_web;
    logic             r_pc_we, r_rf_we, r_dbg_gnt, r_halted, r_trap;

    logic             w_cycle_en;
    logic             w_instret_en;
    logic [CNT_W-1:0] w_cycle_cnt;
    logic [CNT_W-1:0] w_instret_cnt;

    assign w_opcode  = r_ir[6:0];
    assign w_illegal = !is_legal_opcode(w_opcode);
    assign w_halt_op = (w_opcode == OPC_SYSTEM) || w_illegal;
    assign w_mem_op  = (w_opcode == OPC_LOAD) || (w_opcode == OPC_STORE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobes are decoded from the next state so they come out of flops
    // aligned with the phase they belong to.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.dbg_req)   w_next = S_DBG;
                      else if (bus.run)  w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   if (w_halt_op)     w_next = S_HALT;
                      else if (w_mem_op) w_next = S_MEM;
                      else               w_next = S_WB;
            S_MEM:    w_next = S_WB;
            S_WB:     if (bus.dbg_req)   w_next = S_DBG;
                      else if (bus.run)  w_next = S_FETCH;
                      else               w_next = S_IDLE;
            S_DBG:    if (!bus.dbg_req)  w_next = bus.run ? S_FETCH : S_IDLE;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase

        w_imem_csb = (w_next != S_FETCH);
        w_dmem_csb = (w_next != S_MEM);
        w_dmem_web = !((w_next == S_MEM) && (w_opcode == OPC_STORE));
        w_pc_we    = (w_next == S_WB);
        w_rf_we    = (w_next == S_WB) && bus.regwen_dec;
        w_dbg_gnt  = (w_next == S_DBG);
        w_halted   = (w_next == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir       <= '0;
            r_imem_csb <= 1'b1;
            r_dmem_csb <= 1'b1;
            r_dmem_web <= 1'b1;
            r_pc_we    <= 1'b0;
            r_rf_we    <= 1'b0;
            r_dbg_gnt  <= 1'b0;
            r_halted   <= 1'b0;
            r_trap     <= 1'b0;
        end else begin
            if (r_state == S_DECODE) begin
                r_ir <= bus.inst_rdata;
            end
            if ((r_state == S_EXEC) && w_illegal) begin
                r_trap <= 1'b1;
            end
            r_imem_csb <= w_imem_csb;
            r_dmem_csb <= w_dmem_csb;
            r_dmem_web <= w_dmem_web;
            r_pc_we    <= w_pc_we;
            r_rf_we    <= w_rf_we;
            r_dbg_gnt  <= w_dbg_gnt;
            r_halted   <= w_halted;
        end
    end

    assign w_cycle_en   = (r_state != S_IDLE) && (r_state != S_HALT);
    assign w_instret_en = (r_state == S_WB);

    rv32i_perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_cycle_en),
        .count (w_cycle_cnt)
    );

    rv32i_perf_counter #(.CNT_W(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_instret_en),
        .count (w_instret_cnt)
    );

    // A strobe already presented in the cycle reset arrives would still
    // commit at that edge; masking it aborts the write in flight.
    assign bus.pc_we        = r_pc_we & ~reset;
    assign bus.rf_we        = r_rf_we & ~reset;
    assign bus.imem_csb     = r_imem_csb | reset;
    assign bus.dmem_csb     = r_dmem_csb | reset;
    assign bus.dmem_web     = r_dmem_web | reset;
    assign bus.dbg_gnt      = r_dbg_gnt;
    assign bus.halted       = r_halted;
    assign bus.trap_illegal = r_trap;
    assign bus.ir           = r_ir;
    assign bus.cycle_cnt    = w_cycle_cnt;
    assign bus.instret_cnt  = w_instret_cnt;
endmodule
`default_nettype wire

// File: tb/tb_rv32i_mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_rv32i_mc_sequencer
// Brief  : Self-checking bench: per-cycle strobe scoreboard plus counter checks.
// Rev    : 1.0
// ============================================================================
module tb_rv32i_mc_sequencer;
    typedef logic [6:0] strb_t; // {imem_csb,dmem_csb,dmem_web,pc_we,rf_we,dbg_gnt,halted}

    localparam strb_t V_IDLE  = 7'b1110000;
    localparam strb_t V_FETCH = 7'b0110000;
    localparam strb_t V_MID   = 7'b1110000;
    localparam strb_t V_LOAD  = 7'b1010000;
    localparam strb_t V_STORE = 7'b1000000;
    localparam strb_t V_DBG   = 7'b1110010;
    localparam strb_t V_HALT  = 7'b1110001;

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_LW    = 32'h01002103;
    localparam logic [31:0] I_SW    = 32'h00202823;
    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    logic        clk;
    logic        reset;
    logic [31:0] prog [0:7];
    logic [2:0]  pc_idx;
    int          store_cnt;
    int          passed;
    int          total;
    logic [31:0] exp_cycles;
    logic [31:0] exp_instret;
    strb_t       exp_q[$];

    logic        wrap_rst;
    logic        wrap_en;
    logic [3:0]  wrap_cnt;

    rv32i_mc_sequencer_if #(.XLEN(32), .CNT_W(32)) bus ();

    rv32i_mc_sequencer #(.CNT_W(32), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rv32i_perf_counter #(.CNT_W(4)) u_wrap (
        .clk   (clk),
        .reset (wrap_rst),
        .en    (wrap_en),
        .count (wrap_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Control-unit model: no register write for STORE, BRANCH, SYSTEM.
    assign bus.regwen_dec = !((bus.ir[6:0] == 7'b0100011) ||
                              (bus.ir[6:0] == 7'b1100011) ||
                              (bus.ir[6:0] == 7'b1110011));

    // Instruction SRAM (registered dout), PC model and data SRAM write tally.
    always @(posedge clk) begin
        if (reset) begin
            pc_idx         <= 3'd0;
            bus.inst_rdata <= 32'h0;
        end else begin
            if (!bus.imem_csb) bus.inst_rdata <= prog[pc_idx];
            if (bus.pc_we)     pc_idx <= pc_idx + 3'd1;
        end
        if (!bus.dmem_csb && !bus.dmem_web) store_cnt <= store_cnt + 1;
    end

    function automatic strb_t obs_v();
        obs_v = {bus.imem_csb, bus.dmem_csb, bus.dmem_web, bus.pc_we,
                 bus.rf_we, bus.dbg_gnt, bus.halted};
    endfunction

    function automatic logic tb_legal(input logic [6:0] op);
        tb_legal = op inside {7'h03, 7'h23, 7'h73, 7'h33, 7'h13, 7'h63,
                              7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F};
    endfunction

    task automatic push_instr(input logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        exp_q.push_back(V_FETCH);
        exp_q.push_back(V_MID);
        exp_q.push_back(V_MID);
        exp_cycles = exp_cycles + 32'd3;
        if (op == 7'h73 || !tb_legal(op)) begin
            exp_q.push_back(V_HALT);
            return;
        end
        if (op == 7'h03) begin
            exp_q.push_back(V_LOAD);
            exp_cycles = exp_cycles + 32'd1;
        end else if (op == 7'h23) begin
            exp_q.push_back(V_STORE);
            exp_cycles = exp_cycles + 32'd1;
        end
        exp_q.push_back({3'b111, 1'b1, !(op == 7'h23 || op == 7'h63), 2'b00});
        exp_cycles  = exp_cycles + 32'd1;
        exp_instret = exp_instret + 32'd1;
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        bus.run     = 1'b0;
        bus.dbg_req = 1'b0;
        for (int k = 0; k < 8; k++) prog[k] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset       = 1'b0;
        exp_cycles  = 32'd0;
        exp_instret = 32'd0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (obs_v() !== V_IDLE) $display("FAIL reset strobes: got %b want %b", obs_v(), V_IDLE); else passed++;
        total++; if (bus.ir !== 32'h0) $display("FAIL reset ir: got %h want 0", bus.ir); else passed++;
        total++; if (bus.cycle_cnt !== 32'h0 || bus.instret_cnt !== 32'h0)
            $display("FAIL reset counters: got %h/%h want 0/0", bus.cycle_cnt, bus.instret_cnt); else passed++;
        total++; if (bus.trap_illegal !== 1'b0) $display("FAIL reset trap: got %b want 0", bus.trap_illegal); else passed++;
    endtask

    task automatic test_single(input string name, input logic [31:0] inst);
        int n;
        int st0;
        strb_t e;
        apply_reset();
        prog[0] = inst;
        st0 = store_cnt;
        push_instr(inst);
        exp_q.push_back(V_IDLE);
        n = exp_q.size();
        bus.run = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            bus.run = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (obs_v() !== e) $display("FAIL %s cycle %0d strobes: got %b want %b", name, i, obs_v(), e);
            else passed++;
        end
        total++; if (bus.ir !== inst) $display("FAIL %s ir: got %h want %h", name, bus.ir, inst); else passed++;
        total++; if (bus.cycle_cnt !== exp_cycles) $display("FAIL %s cycle_cnt: got %0d want %0d", name, bus.cycle_cnt, exp_cycles); else passed++;
        total++; if (bus.instret_cnt !== exp_instret) $display("FAIL %s instret_cnt: got %0d want %0d", name, bus.instret_cnt, exp_instret); else passed++;
        total++; if ((store_cnt - st0) !== ((inst[6:0] == 7'h23) ? 1 : 0))
            $display("FAIL %s stores: got %0d want %0d", name, store_cnt - st0, (inst[6:0] == 7'h23) ? 1 : 0); else passed++;
    endtask

    task automatic test_dbg();
        int n;
        strb_t e;
        apply_reset();
        prog[0] = I_ADD;
        prog[1] = I_ADD;
        push_instr(I_ADD);
        repeat (3) exp_q.push_back(V_DBG);
        exp_cycles = exp_cycles + 32'd3;
        push_instr(I_ADD);
        exp_q.push_back(V_IDLE);
        n = exp_q.size();
        bus.run = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_v() !== e) $display("FAIL dbg cycle %0d strobes: got %b want %b", i, obs_v(), e);
            else passed++;
            if (i == 3) bus.dbg_req = 1'b1;
            if (i == 7) bus.dbg_req = 1'b0;
            if (i == 8) bus.run = 1'b0;
        end
        total++; if (bus.cycle_cnt !== exp_cycles) $display("FAIL dbg cycle_cnt: got %0d want %0d", bus.cycle_cnt, exp_cycles); else passed++;
        total++; if (bus.instret_cnt !== exp_instret) $display("FAIL dbg instret_cnt: got %0d want %0d", bus.instret_cnt, exp_instret); else passed++;
    endtask

    task automatic test_halt(input string name, input logic [31:0] inst, input logic trap);
        int n;
        strb_t e;
        apply_reset();
        total++; if (bus.halted !== 1'b0 || bus.trap_illegal !== 1'b0)
            $display("FAIL %s pre halted/trap: got %b/%b want 0/0", name, bus.halted, bus.trap_illegal); else passed++;
        prog[0] = inst;
        push_instr(inst);
        repeat (2) exp_q.push_back(V_HALT);
        n = exp_q.size();
        bus.run = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            bus.run = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (obs_v() !== e) $display("FAIL %s cycle %0d strobes: got %b want %b", name, i, obs_v(), e);
            else passed++;
            if (i == 4) bus.dbg_req = 1'b1;
        end
        total++; if (bus.trap_illegal !== trap) $display("FAIL %s trap: got %b want %b", name, bus.trap_illegal, trap); else passed++;
        total++; if (bus.cycle_cnt !== exp_cycles || bus.instret_cnt !== 32'd0)
            $display("FAIL %s counters: got %0d/%0d want %0d/0", name, bus.cycle_cnt, bus.instret_cnt, exp_cycles); else passed++;
    endtask

    task automatic test_reset_abort();
        int st0;
        strb_t e;
        apply_reset();
        prog[0] = I_SW;
        st0 = store_cnt;
        exp_q.push_back(V_FETCH);
        exp_q.push_back(V_MID);
        exp_q.push_back(V_MID);
        exp_q.push_back(V_STORE);
        bus.run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus.run = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (obs_v() !== e) $display("FAIL abort cycle %0d strobes: got %b want %b", i, obs_v(), e);
            else passed++;
        end
        reset = 1'b1;
        #1;
        total++; if (bus.dmem_web !== 1'b1 || bus.pc_we !== 1'b0)
            $display("FAIL abort strobe mask: web=%b pc_we=%b want 1/0", bus.dmem_web, bus.pc_we); else passed++;
        @(negedge clk);
        reset = 1'b0;
        total++; if (obs_v() !== V_IDLE) $display("FAIL abort idle strobes: got %b want %b", obs_v(), V_IDLE); else passed++;
        total++; if (bus.ir !== 32'h0 || bus.cycle_cnt !== 32'h0 || bus.instret_cnt !== 32'h0)
            $display("FAIL abort state: ir=%h cyc=%0d ret=%0d want 0/0/0", bus.ir, bus.cycle_cnt, bus.instret_cnt); else passed++;
        @(negedge clk);
        total++; if (store_cnt !== st0) $display("FAIL abort stores: got %0d want %0d", store_cnt - st0, 0); else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        int st0;
        strb_t e;
        apply_reset();
        prog[0] = I_ADDI;
        prog[1] = I_LW;
        prog[2] = I_SW;
        st0 = store_cnt;
        push_instr(I_ADDI);
        push_instr(I_LW);
        push_instr(I_SW);
        exp_q.push_back(V_IDLE);
        n = exp_q.size();
        bus.run = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_v() !== e) $display("FAIL b2b cycle %0d strobes: got %b want %b", i, obs_v(), e);
            else passed++;
            if (i == 10) bus.run = 1'b0;
        end
        total++; if (bus.cycle_cnt !== exp_cycles) $display("FAIL b2b cycle_cnt: got %0d want %0d", bus.cycle_cnt, exp_cycles); else passed++;
        total++; if (bus.instret_cnt !== exp_instret) $display("FAIL b2b instret_cnt: got %0d want %0d", bus.instret_cnt, exp_instret); else passed++;
        total++; if ((store_cnt - st0) !== 1) $display("FAIL b2b stores: got %0d want 1", store_cnt - st0); else passed++;
    endtask

    task automatic test_wrap();
        wrap_rst = 1'b1;
        wrap_en  = 1'b0;
        @(negedge clk);
        wrap_rst = 1'b0;
        wrap_en  = 1'b1;
        repeat (15) @(negedge clk);
        total++; if (wrap_cnt !== 4'hF) $display("FAIL wrap top: got %h want f", wrap_cnt); else passed++;
        @(negedge clk);
        total++; if (wrap_cnt !== 4'h0) $display("FAIL wrap rollover: got %h want 0", wrap_cnt); else passed++;
        wrap_en = 1'b0;
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        store_cnt   = 0;
        reset       = 1'b1;
        bus.run     = 1'b0;
        bus.dbg_req = 1'b0;
        wrap_rst    = 1'b1;
        wrap_en     = 1'b0;
        exp_cycles  = 32'd0;
        exp_instret = 32'd0;

        test_reset();
        test_single("addi", I_ADDI);
        test_single("lw", I_LW);
        test_single("sw", I_SW);
        test_dbg();
        test_halt("ecall", I_ECALL, 1'b0);
        test_halt("illegal", I_BAD, 1'b1);
        test_reset_abort();
        test_back_to_back();
        test_wrap();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
